ex_madd_msub: RTL
=================

Name: ex_madd_msub

Overview:
- EX-stage multi-cycle multiply-accumulate sequencer for MADD, MADDU, MSUB and MSUBU.
- Produces the intermediate product and step counter that the EX/MEM pipeline register holds and feeds back while EX is stalled.
- Consumes that fed-back value on the following cycles, accumulates it into HI/LO, and issues the stall request to the stall controller.

Parameters:
- DW, 32, operand width; HI and LO are each DW bits.
- HALF, DW/2, partial-product split width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- op_valid  in  1  EX holds a MAC instruction
- op  in  2  00 MADD, 01 MADDU, 10 MSUB, 11 MSUBU
- src_a  in  32  rs value, forwarded
- src_b  in  32  rt value, forwarded
- hilo_cur  in  64  current {HI,LO}, after forwarding
- flush  in  1  annul the in-flight instruction
- hilo_temp_i  in  64  held intermediate from EX/MEM pipe register
- counter_i  in  2  held step counter from EX/MEM pipe register
- hilo_temp_o  out  64  intermediate to EX/MEM pipe register
- counter_o  out  2  next step counter to EX/MEM pipe register
- stall_req  out  1  EX stall request
- hilo_wr_en  out  1  HI/LO write enable
- hi_o  out  32  HI write data
- lo_o  out  32  LO write data

Behaviour:
- One clock, clk; reset is synchronous, active-high.
- Internal registers: pp_ll, pp_lh, pp_hl, pp_hh (32b each) and neg_q (1b). All clear to 0 on reset or flush.
- Reset (overrides all): stall_req=0, hilo_wr_en=0, counter_o=00, hilo_temp_o=0, hi_o=lo_o=0.
- Signedness and magnitudes:
  - signed = ~op[0]; sub = op[1].
  - Signed ops use |src_a| and |src_b|; |0x8000_0000| = 0x8000_0000 as unsigned. Unsigned ops use raw values.
- Step 00 (counter_i==00, op_valid, !flush):
  - Register the four HALFxHALF partials of the magnitudes.
  - neg_q <= (signed & (src_a[31]^src_b[31])) ^ sub.
  - counter_o=01, stall_req=1, hilo_temp_o=0, hilo_wr_en=0.
- Step 01 (counter_i==01):
  - prod = (pp_hh<<32) + ((pp_lh+pp_hl)<<16) + pp_ll, computed mod 2^64.
  - hilo_temp_o = neg_q ? -prod : prod.
  - counter_o=10, stall_req=1, hilo_wr_en=0.
- Step 10 (counter_i==10):
  - {hi_o,lo_o} = hilo_temp_i + hilo_cur, mod 2^64.
  - hilo_wr_en=1, stall_req=0, counter_o=00, hilo_temp_o=0.
- Idle (counter_i==00 & !op_valid), or counter_i==11 (illegal): all outputs at reset values; internal regs hold.
- Latency: three EX cycles; stall_req is high for exactly two of them. The pipe register holds hilo_temp/counter only while stall[3]=1 and stall[4]=0, so the stall controller must not raise stall[4] during the op.
- flush in any step: that cycle drives stall_req=0, hilo_wr_en=0, counter_o=00; internal regs clear next edge.
- Reset mid-op: same as flush. No HI/LO write occurs for the aborted instruction.
- hilo_cur is sampled at step 10 only, so a HI/LO write landing during steps 00/01 is honoured via forwarding.

Decomposition:
- Shared package holds the MAC op encodings (MADD/MADDU/MSUB/MSUBU) and counter step constants (STEP_MUL=00, STEP_SUM=01, STEP_ACC=10).
- One natural sub-module: mac_pp_mul, the magnitude split plus registered 16x16 partial products and sign flag.

Test Plan:
- MADD a=3, b=0xFFFF_FFFE (-2), hilo=10 -> temp 0xFFFF_FFFF_FFFF_FFFA; step 10 hi=0, lo=4; stall high 2 cycles.
- MADDU a=b=0xFFFF_FFFF, hilo=0 -> hi=0xFFFF_FFFE, lo=0x0000_0001.
- MSUB a=b=0x8000_0000, hilo=0 -> temp = {hi,lo} = 0xC000_0000_0000_0000.
- MSUBU a=1, b=1, hilo=0 -> hi=lo=0xFFFF_FFFF (wrap); hilo_wr_en pulses one cycle.
- flush asserted at counter_i=01 -> stall_req=0, counter_o=00, no hilo_wr_en; next MADD 2*2 on hilo=0 -> lo=4.
- reset asserted at counter_i=10 -> hilo_wr_en=0, all outputs at reset values; internal regs 0 after the edge.

Source files
------------

// File: rtl/ex_madd_msub_pkg.sv
// Shared widths, MAC op encodings and step-counter values for the EX-stage MADD/MSUB sequencer.
package ex_madd_msub_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned HALF = DW / 2;
  localparam int unsigned HW   = 2 * DW;

  typedef enum logic [1:0] {
    OP_MADD  = 2'b00,
    OP_MADDU = 2'b01,
    OP_MSUB  = 2'b10,
    OP_MSUBU = 2'b11
  } mac_op_e;

  typedef enum logic [1:0] {
    STEP_MUL = 2'b00,
    STEP_SUM = 2'b01,
    STEP_ACC = 2'b10,
    STEP_BAD = 2'b11
  } step_e;

endpackage

// File: rtl/ex_madd_msub_pp_mul.sv
// Magnitude split of the operands and registered HALFxHALF partial products plus result-sign flag.
module ex_madd_msub_pp_mul
  import ex_madd_msub_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic [1:0]    op,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  output logic [DW-1:0] pp_ll,
  output logic [DW-1:0] pp_lh,
  output logic [DW-1:0] pp_hl,
  output logic [DW-1:0] pp_hh,
  output logic          neg_q
);

  logic          is_signed;
  logic          is_sub;
  logic [DW-1:0] mag_a;
  logic [DW-1:0] mag_b;

  // Two's-complement negate maps 0x8000_0000 onto itself, which is the correct unsigned magnitude.
  always_comb begin
    is_signed = ~op[0];
    is_sub    = op[1];
    mag_a     = (is_signed && src_a[DW-1]) ? (~src_a + DW'(1)) : src_a;
    mag_b     = (is_signed && src_b[DW-1]) ? (~src_b + DW'(1)) : src_b;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pp_ll <= '0;
      pp_lh <= '0;
      pp_hl <= '0;
      pp_hh <= '0;
      neg_q <= 1'b0;
    end else if (load) begin
      pp_ll <= DW'(mag_a[HALF-1:0])  * DW'(mag_b[HALF-1:0]);
      pp_lh <= DW'(mag_a[HALF-1:0])  * DW'(mag_b[DW-1:HALF]);
      pp_hl <= DW'(mag_a[DW-1:HALF]) * DW'(mag_b[HALF-1:0]);
      pp_hh <= DW'(mag_a[DW-1:HALF]) * DW'(mag_b[DW-1:HALF]);
      neg_q <= (is_signed & (src_a[DW-1] ^ src_b[DW-1])) ^ is_sub;
    end
  end

endmodule

// File: rtl/ex_madd_msub.sv
// EX-stage MADD/MADDU/MSUB/MSUBU sequencer; step state lives in the EX/MEM register and is fed back.
module ex_madd_msub
  import ex_madd_msub_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  input  logic [1:0]    op,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic [HW-1:0] hilo_cur,
  input  logic          flush,
  input  logic [HW-1:0] hilo_temp_i,
  input  logic [1:0]    counter_i,
  output logic [HW-1:0] hilo_temp_o,
  output logic [1:0]    counter_o,
  output logic          stall_req,
  output logic          hilo_wr_en,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  logic          load;
  logic [DW-1:0] pp_ll;
  logic [DW-1:0] pp_lh;
  logic [DW-1:0] pp_hl;
  logic [DW-1:0] pp_hh;
  logic          neg_q;
  logic [HW-1:0] mid;
  logic [HW-1:0] prod;

  assign load = op_valid && (step_e'(counter_i) == STEP_MUL);

  ex_madd_msub_pp_mul u_pp (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (load),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .pp_ll (pp_ll),
    .pp_lh (pp_lh),
    .pp_hl (pp_hl),
    .pp_hh (pp_hh),
    .neg_q (neg_q)
  );

  // Recombine the registered partials; the middle sum can carry into bit DW, so widen first.
  always_comb begin
    mid  = HW'(pp_lh) + HW'(pp_hl);
    prod = {pp_hh, DW'(0)} + (mid << HALF) + HW'(pp_ll);
  end

  // Per-step outputs; reset, flush, idle and the illegal counter value all leave the defaults.
  always_comb begin
    hilo_temp_o = '0;
    counter_o   = STEP_MUL;
    stall_req   = 1'b0;
    hilo_wr_en  = 1'b0;
    hi_o        = '0;
    lo_o        = '0;
    if (!reset && !flush) begin
      case (step_e'(counter_i))
        STEP_MUL: begin
          if (op_valid) begin
            counter_o = STEP_SUM;
            stall_req = 1'b1;
          end
        end
        STEP_SUM: begin
          hilo_temp_o = neg_q ? (~prod + HW'(1)) : prod;
          counter_o   = STEP_ACC;
          stall_req   = 1'b1;
        end
        STEP_ACC: begin
          {hi_o, lo_o} = hilo_temp_i + hilo_cur;
          hilo_wr_en   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
